case_3_sdiv_5s_3s_5_seq_1: RTL

Sequential signed integer divider, the inverse of the operator-bank signed multipliers. It computes quotient and remainder of a din0_WIDTH-bit signed dividend by a din1_WIDTH-bit signed divisor, one quotient bit per cycle, using a start/done handshake with a clock-enable. It sits beside the multiplier cores inside the datapath and is shared by the FSM, which issues one division at a time.

---
 rtl/case_3_sdiv_5s_3s_5_seq_1.sv | 113 +++++++++++
 1 files changed

// File: rtl/case_3_sdiv_5s_3s_5_seq_1.sv
// Sequential restoring signed divider: one quotient bit per enabled cycle,
// truncating toward zero, with a start/done handshake and a clock enable.
module case_3_sdiv_5s_3s_5_seq_1 #(
    parameter int din0_WIDTH = 5,
    parameter int din1_WIDTH = 3,
    parameter int dout_WIDTH = 5,
    parameter int ID         = 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         ce,
    input  logic                         start,
    input  logic signed [din0_WIDTH-1:0] dividend,
    input  logic signed [din1_WIDTH-1:0] divisor,
    output logic                         done,
    output logic                         busy,
    output logic signed [dout_WIDTH-1:0] quot,
    output logic signed [din1_WIDTH-1:0] remd
);

    localparam int CNT_W = $clog2(din0_WIDTH + 1);

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t                  state;
    logic [CNT_W-1:0]        cnt;
    logic [din0_WIDTH-1:0]   dd_mag;   // dividend magnitude; quotient bits shift in at the LSB
    logic [din1_WIDTH-1:0]   dv_mag;
    logic [din1_WIDTH:0]     prem;
    logic                    sign_q;
    logic                    sign_r;
    logic                    div_zero;

    logic [din1_WIDTH:0]     shifted;
    logic [din1_WIDTH+1:0]   trial;

    function automatic logic [din0_WIDTH-1:0] cneg0(input logic [din0_WIDTH-1:0] v,
                                                    input logic neg);
        return neg ? (~v + din0_WIDTH'(1)) : v;
    endfunction

    function automatic logic [din1_WIDTH-1:0] cneg1(input logic [din1_WIDTH-1:0] v,
                                                    input logic neg);
        return neg ? (~v + din1_WIDTH'(1)) : v;
    endfunction

    assign shifted = {prem[din1_WIDTH-1:0], dd_mag[din0_WIDTH-1]};
    assign trial   = {1'b0, shifted} - {2'b00, dv_mag};

    // Control and result registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            done  <= 1'b0;
            busy  <= 1'b0;
            quot  <= '0;
            remd  <= '0;
        end else if (ce) begin
            unique case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        state <= CALC;
                        cnt   <= '0;
                        busy  <= 1'b1;
                    end
                end
                CALC: begin
                    cnt <= cnt + CNT_W'(1);
                    if (cnt == CNT_W'(din0_WIDTH - 1))
                        state <= FIX;
                end
                FIX: begin
                    if (div_zero) begin
                        quot <= '1;
                        remd <= '0;
                    end else begin
                        quot <= cneg0(dd_mag, sign_q);
                        remd <= cneg1(prem[din1_WIDTH-1:0], sign_r);
                    end
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Datapath: operand capture, then one restoring step per CALC cycle
    always_ff @(posedge clk) begin
        if (ce) begin
            if (state == IDLE && start) begin
                sign_q   <= dividend[din0_WIDTH-1] ^ divisor[din1_WIDTH-1];
                sign_r   <= dividend[din0_WIDTH-1];
                dd_mag   <= cneg0(dividend, dividend[din0_WIDTH-1]);
                dv_mag   <= cneg1(divisor, divisor[din1_WIDTH-1]);
                div_zero <= (divisor == '0);
                prem     <= '0;
            end else if (state == CALC) begin
                if (!trial[din1_WIDTH+1]) begin
                    prem   <= trial[din1_WIDTH:0];
                    dd_mag <= {dd_mag[din0_WIDTH-2:0], 1'b1};
                end else begin
                    prem   <= shifted;
                    dd_mag <= {dd_mag[din0_WIDTH-2:0], 1'b0};
                end
            end
        end
    end

endmodule
